// File: rtl/unified_mem_responder.sv
// Unified instruction/data memory responder with configurable wait states.
// Byte-addressed little-endian array, RV32I load/store sizing, misalignment flag.
module unified_mem_responder #(
    parameter int DEPTH_BYTES = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        busy,
    output logic        misaligned
);
    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            isStore_q, isLoad_q;
    logic [2:0]      f3_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     data_out_q, data_out_d;
    logic            misaligned_q, misaligned_d;

    logic [7:0]      mem [DEPTH_BYTES];

    logic            accept, enterResp, writeEn;
    logic            cStore, cLoad;
    logic [2:0]      cF3;
    logic [AW-1:0]   a0;
    logic [31:0]     cData;
    logic [1:0]      sizeCode;
    logic            noAccess;
    logic [31:0]     rword, loadVal;
    logic            unusedBits;

    assign unusedBits = ^addr[31:AW];

    assign accept    = (state_q == ST_IDLE) && req_valid;
    assign enterResp = (state_d == ST_RESP) && (state_q != ST_RESP);

    // With zero wait states the access happens on the accepting edge, so the
    // live inputs must be used before they have been latched.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cStore = MemWrite;
            cLoad  = MemRead && !MemWrite;
            cF3    = func3;
            a0     = addr[AW-1:0];
            cData  = data_in;
        end else begin
            cStore = isStore_q;
            cLoad  = isLoad_q;
            cF3    = f3_q;
            a0     = addr_q;
            cData  = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            isStore_q    <= 1'b0;
            isLoad_q     <= 1'b0;
            f3_q         <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            data_out_q   <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                isStore_q <= MemWrite;
                isLoad_q  <= MemRead && !MemWrite;
                f3_q      <= func3;
                addr_q    <= addr[AW-1:0];
                wdata_q   <= data_in;
            end
            if (enterResp) begin
                data_out_q   <= data_out_d;
                misaligned_q <= misaligned_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_d = 4'(WAIT_STATES);
                    if (WAIT_STATES > 0) state_d = ST_WAIT;
                    else                 state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready      = (state_q == ST_RESP);
        busy       = (state_q != ST_IDLE);
        data_out   = data_out_q;
        misaligned = misaligned_q;
    end

    // sizeCode: 0 byte, 1 half, 2 word; stores with unknown codes touch nothing.
    always_comb begin
        noAccess = 1'b0;
        sizeCode = 2'd2;
        if (cStore) begin
            case (cF3)
                3'b000:  sizeCode = 2'd0;
                3'b001:  sizeCode = 2'd1;
                3'b010:  sizeCode = 2'd2;
                default: noAccess = 1'b1;
            endcase
        end else if (cLoad) begin
            case (cF3[1:0])
                2'b00:   sizeCode = 2'd0;
                2'b01:   sizeCode = 2'd1;
                default: sizeCode = 2'd2;
            endcase
        end
        misaligned_d = !noAccess &&
                       (((sizeCode == 2'd1) && a0[0]) ||
                        ((sizeCode == 2'd2) && (a0[1:0] != 2'b00)));
        rword = {mem[a0 + AW'(3)], mem[a0 + AW'(2)], mem[a0 + AW'(1)], mem[a0]};
        case (sizeCode)
            2'd0:    loadVal = cF3[2] ? {24'd0, rword[7:0]} : {{24{rword[7]}}, rword[7:0]};
            2'd1:    loadVal = cF3[2] ? {16'd0, rword[15:0]} : {{16{rword[15]}}, rword[15:0]};
            default: loadVal = rword;
        endcase
        data_out_d = (misaligned_d || cStore) ? 32'd0 : loadVal;
        writeEn    = enterResp && cStore && !noAccess && !misaligned_d && !rst;
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[a0] <= cData[7:0];
            if (sizeCode != 2'd0) mem[a0 + AW'(1)] <= cData[15:8];
            if (sizeCode == 2'd2) begin
                mem[a0 + AW'(2)] <= cData[23:16];
                mem[a0 + AW'(3)] <= cData[31:24];
            end
        end
    end
endmodule

// File: tb/tb_unified_mem_responder.sv
// Self-checking bench: instance 0 runs with two wait states, instance 1 with none.
module tb_unified_mem_responder;
    localparam logic [1:0] OP_FETCH = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_BOTH = 2'b11;

    logic        clk;
    logic        rst [2];
    logic        rv [2];
    logic        mr [2];
    logic        mw [2];
    logic [2:0]  f3 [2];
    logic [31:0] ad [2];
    logic [31:0] di [2];
    logic [31:0] dout [2];
    logic        rdy [2];
    logic        bsy [2];
    logic        mis [2];

    int errors = 0;
    int checks = 0;
    int wsOf [2] = '{2, 0};

    logic [7:0] mm [2][4096];

    unified_mem_responder #(.DEPTH_BYTES(4096), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .MemRead(mr[0]), .MemWrite(mw[0]),
        .func3(f3[0]), .addr(ad[0]), .data_in(di[0]), .data_out(dout[0]),
        .ready(rdy[0]), .busy(bsy[0]), .misaligned(mis[0])
    );

    unified_mem_responder #(.DEPTH_BYTES(4096), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .MemRead(mr[1]), .MemWrite(mw[1]),
        .func3(f3[1]), .addr(ad[1]), .data_in(di[1]), .data_out(dout[1]),
        .ready(rdy[1]), .busy(bsy[1]), .misaligned(mis[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: size from the op, alignment by modulo, bytes assembled arithmetically.
    task automatic model(input int s, input logic [1:0] op, input logic [2:0] fc,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] ed, output logic em);
        int ea, size;
        logic [31:0] w;
        ea = int'(a % 32'd4096);
        if (op[1])      size = (fc == 3'd0) ? 1 : (fc == 3'd1) ? 2 : (fc == 3'd2) ? 4 : 0;
        else if (op[0]) size = (fc[1:0] == 2'd0) ? 1 : (fc[1:0] == 2'd1) ? 2 : 4;
        else            size = 4;
        em = 1'b0;
        if (size != 0) em = (ea % size) != 0;
        ed = 32'd0;
        w  = 32'd0;
        if (size == 0 || em) return;
        for (int i = 0; i < size; i++) begin
            if (op[1]) mm[s][ea + i] = d[8*i +: 8];
            else       w = w + (32'(mm[s][ea + i]) << (8 * i));
        end
        if (!op[1]) begin
            if (op[0] && !fc[2] && size == 1 && w >= 32'd128)   w = w - 32'd256;
            if (op[0] && !fc[2] && size == 2 && w >= 32'd32768) w = w - 32'd65536;
            ed = w;
        end
    endtask

    // Drives one request, scrambles inputs while the access is in flight, waits for ready.
    task automatic access(input int s, input logic [1:0] op, input logic [2:0] fc,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] od, output logic om,
                          output int lat, output int busyCnt);
        @(negedge clk);
        rv[s] = 1'b1; mw[s] = op[1]; mr[s] = op[0]; f3[s] = fc; ad[s] = a; di[s] = d;
        @(posedge clk);
        #1;
        rv[s] = 1'($urandom); mw[s] = 1'($urandom); mr[s] = 1'($urandom);
        f3[s] = 3'($urandom); ad[s] = $urandom; di[s] = $urandom;
        lat = 0; busyCnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bsy[s] && !rdy[s]) busyCnt++;
        end while (!rdy[s] && lat < 40);
        od = dout[s];
        om = mis[s];
        rv[s] = 1'b0;
    endtask

    task automatic test_reset;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; rv[s] = 1'b0; mr[s] = 1'b0; mw[s] = 1'b0;
            f3[s] = 3'd0; ad[s] = 32'd0; di[s] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++; if (rdy[s] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready inst=%0d got=%b exp=0", s, rdy[s]); end
            checks++; if (bsy[s] !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy inst=%0d got=%b exp=0", s, bsy[s]); end
            checks++; if (mis[s] !== 1'b0) begin errors++; $display("[TB] FAIL reset_misaligned inst=%0d got=%b exp=0", s, mis[s]); end
            checks++; if (dout[s] !== 32'd0) begin errors++; $display("[TB] FAIL reset_data_out inst=%0d got=%h exp=0", s, dout[s]); end
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
    endtask

    task automatic test_fetch;
        logic [31:0] od, ed; logic om, em; int lat, bc;
        model(0, OP_STORE, 3'd2, 32'h10, 32'h00A00093, ed, em);
        access(0, OP_STORE, 3'd2, 32'h10, 32'h00A00093, od, om, lat, bc);
        model(0, OP_FETCH, 3'd5, 32'h10, 32'h0, ed, em);
        access(0, OP_FETCH, 3'd5, 32'h10, 32'h0, od, om, lat, bc);
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL fetch_latency got=%0d exp=3", lat); end
        checks++; if (bc !== 2) begin errors++; $display("[TB] FAIL fetch_busy_cycles got=%0d exp=2", bc); end
        checks++; if (od !== 32'h00A00093) begin errors++; $display("[TB] FAIL fetch_data got=%h exp=00a00093", od); end
        checks++; if (om !== 1'b0) begin errors++; $display("[TB] FAIL fetch_misaligned got=%b exp=0", om); end
    endtask

    task automatic test_load_sizes;
        logic [31:0] od, ed; logic om, em; int lat, bc;
        logic [2:0]  tf3 [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0};
        logic [31:0] tad [5] = '{32'h20, 32'h20, 32'h20, 32'h20, 32'h21};
        logic [31:0] texp [5] = '{32'h0000007F, 32'h0000007F, 32'hFFFFFF7F, 32'h0000FF7F, 32'hFFFFFFFF};
        model(0, OP_STORE, 3'd2, 32'h20, 32'h8000FF7F, ed, em);
        access(0, OP_STORE, 3'd2, 32'h20, 32'h8000FF7F, od, om, lat, bc);
        for (int i = 0; i < 5; i++) begin
            access(0, OP_LOAD, tf3[i], tad[i], 32'h0, od, om, lat, bc);
            checks++; if (od !== texp[i]) begin errors++; $display("[TB] FAIL load_size[%0d] f3=%0d got=%h exp=%h", i, tf3[i], od, texp[i]); end
        end
    endtask

    task automatic test_byte_store;
        logic [31:0] od, ed; logic om, em; int lat, bc;
        model(0, OP_STORE, 3'd2, 32'h20, 32'h11223344, ed, em);
        access(0, OP_STORE, 3'd2, 32'h20, 32'h11223344, od, om, lat, bc);
        model(0, OP_STORE, 3'd0, 32'h22, 32'hFFFFFFAB, ed, em);
        access(0, OP_STORE, 3'd0, 32'h22, 32'hFFFFFFAB, od, om, lat, bc);
        access(0, OP_LOAD, 3'd2, 32'h20, 32'h0, od, om, lat, bc);
        checks++; if (od !== 32'h11AB3344) begin errors++; $display("[TB] FAIL sb_merge got=%h exp=11ab3344", od); end
    endtask

    task automatic test_misaligned;
        logic [31:0] od; logic om; int lat, bc;
        access(0, OP_LOAD, 3'd2, 32'h23, 32'h0, od, om, lat, bc);
        checks++; if (om !== 1'b1) begin errors++; $display("[TB] FAIL lw_misaligned_flag got=%b exp=1", om); end
        checks++; if (od !== 32'd0) begin errors++; $display("[TB] FAIL lw_misaligned_data got=%h exp=0", od); end
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL lw_misaligned_latency got=%0d exp=3", lat); end
        access(0, OP_STORE, 3'd1, 32'h21, 32'h0000BEEF, od, om, lat, bc);
        checks++; if (om !== 1'b1) begin errors++; $display("[TB] FAIL sh_misaligned_flag got=%b exp=1", om); end
        access(0, OP_LOAD, 3'd2, 32'h20, 32'h0, od, om, lat, bc);
        checks++; if (od !== 32'h11AB3344) begin errors++; $display("[TB] FAIL sh_misaligned_nowrite got=%h exp=11ab3344", od); end
        checks++; if (om !== 1'b0) begin errors++; $display("[TB] FAIL aligned_flag got=%b exp=0", om); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] od, ed; logic om, em; int lat, bc;
        model(0, OP_STORE, 3'd2, 32'h40, 32'h5A5A0001, ed, em);
        access(0, OP_STORE, 3'd2, 32'h40, 32'h5A5A0001, od, om, lat, bc);
        access(0, OP_LOAD, 3'd2, 32'h40, 32'h0, od, om, lat, bc);
        @(negedge clk);
        rv[0] = 1'b1; mw[0] = 1'b1; mr[0] = 1'b0; f3[0] = 3'd2; ad[0] = 32'h40; di[0] = 32'hDEADBEEF;
        @(posedge clk);
        #1 rv[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        checks++; if (rdy[0] !== 1'b0) begin errors++; $display("[TB] FAIL abort_ready got=%b exp=0", rdy[0]); end
        checks++; if (bsy[0] !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%b exp=0", bsy[0]); end
        checks++; if (dout[0] !== 32'd0) begin errors++; $display("[TB] FAIL abort_data_out got=%h exp=0", dout[0]); end
        rst[0] = 1'b0;
        access(0, OP_LOAD, 3'd2, 32'h40, 32'h0, od, om, lat, bc);
        checks++; if (od !== 32'h5A5A0001) begin errors++; $display("[TB] FAIL abort_no_commit got=%h exp=5a5a0001", od); end
    endtask

    task automatic test_random;
        logic [31:0] od, ed, a, d; logic om, em; int lat, bc;
        logic [1:0] op; logic [2:0] fc;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 16; k++) begin
                d = $urandom;
                model(s, OP_STORE, 3'd2, 32'h100 + 32'(4 * k), d, ed, em);
                access(s, OP_STORE, 3'd2, 32'h100 + 32'(4 * k), d, od, om, lat, bc);
            end
            for (int n = 0; n < 60; n++) begin
                op = 2'($urandom);
                fc = op[1] ? 3'($urandom_range(0, 2)) : 3'($urandom);
                a  = ($urandom & 32'hFFFFF000) | (32'h100 + 32'($urandom_range(0, 63)));
                d  = $urandom;
                model(s, op, fc, a, d, ed, em);
                access(s, op, fc, a, d, od, om, lat, bc);
                checks++; if (lat !== wsOf[s] + 1) begin errors++; $display("[TB] FAIL rand_latency inst=%0d n=%0d got=%0d exp=%0d", s, n, lat, wsOf[s] + 1); end
                checks++; if (om !== em) begin errors++; $display("[TB] FAIL rand_misaligned inst=%0d n=%0d op=%0d f3=%0d addr=%h got=%b exp=%b", s, n, op, fc, a, om, em); end
                if (!op[1]) begin
                    checks++; if (od !== ed) begin errors++; $display("[TB] FAIL rand_data inst=%0d n=%0d op=%0d f3=%0d addr=%h got=%h exp=%h", s, n, op, fc, a, od, ed); end
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] od, ed, expData; logic om, em; int lat, bc;
        model(1, OP_STORE, 3'd2, 32'h10, 32'h13572468, ed, em);
        access(1, OP_STORE, 3'd2, 32'h10, 32'h13572468, od, om, lat, bc);
        model(1, OP_STORE, 3'd2, 32'h14, 32'h0BADF00D, ed, em);
        access(1, OP_STORE, 3'd2, 32'h14, 32'h0BADF00D, od, om, lat, bc);
        @(negedge clk);
        rv[1] = 1'b1; mr[1] = 1'b1; mw[1] = 1'b0; f3[1] = 3'd2; ad[1] = 32'h1010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (rdy[1] !== ((i % 2) == 0)) begin errors++; $display("[TB] FAIL b2b_ready cycle=%0d got=%b exp=%b", i, rdy[1], (i % 2) == 0); end
            if (rdy[1]) begin
                expData = (ad[1] == 32'h1010) ? 32'h13572468 : 32'h0BADF00D;
                checks++; if (dout[1] !== expData) begin errors++; $display("[TB] FAIL b2b_data cycle=%0d addr=%h got=%h exp=%h", i, ad[1], dout[1], expData); end
                ad[1] = (ad[1] == 32'h1010) ? 32'h14 : 32'h1010;
            end
        end
        rv[1] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load_sizes();
        test_byte_store();
        test_misaligned();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
